// File: rtl/AXI_package.sv
// Shared definitions for the register-command responder: register width,
// host command encodings, responder state type and status bit positions.
package AXI_package;

  localparam int REG_WIDTH = 32;

  localparam logic [REG_WIDTH-1:0] CMD_NOP   = 32'd0;
  localparam logic [REG_WIDTH-1:0] CMD_WRITE = 32'd1;
  localparam logic [REG_WIDTH-1:0] CMD_READ  = 32'd2;
  localparam logic [REG_WIDTH-1:0] CMD_CLEAR = 32'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_HOLD  = 2'd2
  } resp_state_t;

  localparam int STAT_BUSY     = 0;
  localparam int STAT_ERROR    = 1;
  localparam int STAT_RVALID   = 2;
  localparam int STAT_WCNT_LSB = 16;

  // Each 32-bit memory word packs two instructions; hi selects [31:16].
  function automatic logic [15:0] half_sel(input logic [31:0] word, input logic hi);
    return hi ? word[31:16] : word[15:0];
  endfunction

endpackage

// File: rtl/cicero_instr_mem.sv
// True dual-port instruction memory: port A host read/write, port B core
// read-only; both reads registered and read-first.
module cicero_instr_mem #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_a_en,
  input  logic          i_a_we,
  input  logic [AW-1:0] i_a_addr,
  input  logic [DW-1:0] i_a_wdata,
  output logic [DW-1:0] o_a_rdata,
  input  logic [AW-1:0] i_b_addr,
  output logic [DW-1:0] o_b_rdata
);

  logic [DW-1:0] r_mem [2**AW];

  // Array contents are deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (i_a_en && i_a_we) r_mem[i_a_addr] <= i_a_wdata;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_a_rdata <= '0;
    end else if (i_a_en) begin
      o_a_rdata <= r_mem[i_a_addr];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) o_b_rdata <= '0;
    else       o_b_rdata <= r_mem[i_b_addr];
  end

endmodule

// File: rtl/cicero_reg_responder.sv
// Host register-command responder for the regex instruction memory.
// Optional write counter in status[31:16] enabled by CICERO_WRITE_COUNT_EN.
module cicero_reg_responder
  import AXI_package::*;
#(
  parameter int MEM_ADDR_WIDTH = 9
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [REG_WIDTH-1:0]      data_in_register,
  input  logic [REG_WIDTH-1:0]      address_register,
  input  logic [REG_WIDTH-1:0]      cmd_register,
  output logic [REG_WIDTH-1:0]      status_register,
  output logic [REG_WIDTH-1:0]      data_o_register,
  input  logic [MEM_ADDR_WIDTH-1:0] core_rd_addr,
  output logic [15:0]               core_rd_data,
  output resp_state_t               o_dbg_state
);

  localparam int WORD_AW = MEM_ADDR_WIDTH - 1;

  resp_state_t        r_state, w_next_state;
  logic [WORD_AW-1:0] r_clr_cnt;
  logic               r_valid1, r_sel1, r_oor1;
  logic               r_read_valid, r_error, r_core_sel;
  logic [15:0]        r_data_o;
  logic [15:0]        w_wr_cnt;

  logic               w_in_range, w_host_wr, w_host_rd, w_bad_wr, w_clr_start;
  logic               w_a_en, w_a_we;
  logic [WORD_AW-1:0] w_a_addr;
  logic [31:0]        w_a_wdata, w_a_rdata, w_b_rdata;

  assign w_in_range  = (address_register[REG_WIDTH-1:MEM_ADDR_WIDTH] == '0);
  assign o_dbg_state = r_state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_a_en       = 1'b0;
    w_a_we       = 1'b0;
    w_a_addr     = address_register[MEM_ADDR_WIDTH-1:1];
    w_a_wdata    = data_in_register[31:0];
    w_host_wr    = 1'b0;
    w_host_rd    = 1'b0;
    w_bad_wr     = 1'b0;
    w_clr_start  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        case (cmd_register)
          CMD_WRITE: begin
            if (w_in_range && !address_register[0]) begin
              w_a_en    = 1'b1;
              w_a_we    = 1'b1;
              w_host_wr = 1'b1;
            end else begin
              w_bad_wr = 1'b1;
            end
          end
          CMD_READ: begin
            w_host_rd = 1'b1;
            w_a_en    = w_in_range;
          end
          CMD_CLEAR: begin
            w_clr_start  = 1'b1;
            w_next_state = ST_CLEAR;
          end
          default: ;
        endcase
      end
      ST_CLEAR: begin
        w_a_en    = 1'b1;
        w_a_we    = 1'b1;
        w_a_addr  = r_clr_cnt;
        w_a_wdata = '0;
        if (r_clr_cnt == '1) w_next_state = ST_HOLD;
      end
      ST_HOLD: begin
        // Wait for the host to drop CLEAR so a held command cannot retrigger.
        if (cmd_register != CMD_CLEAR) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clr_cnt    <= '0;
      r_valid1     <= 1'b0;
      r_sel1       <= 1'b0;
      r_oor1       <= 1'b0;
      r_read_valid <= 1'b0;
      r_error      <= 1'b0;
      r_data_o     <= '0;
      r_core_sel   <= 1'b0;
    end else begin
      if (w_clr_start)               r_clr_cnt <= '0;
      else if (r_state == ST_CLEAR)  r_clr_cnt <= r_clr_cnt + 1'b1;
      r_valid1     <= w_host_rd;
      r_sel1       <= address_register[0];
      r_oor1       <= !w_in_range;
      r_read_valid <= r_valid1;
      if (r_valid1) r_data_o <= r_oor1 ? 16'h0 : half_sel(w_a_rdata, r_sel1);
      if (w_clr_start)                               r_error <= 1'b0;
      else if (w_bad_wr || (w_host_rd && !w_in_range)) r_error <= 1'b1;
      r_core_sel   <= core_rd_addr[0];
    end
  end

`ifdef CICERO_WRITE_COUNT_EN
  logic [15:0] r_wr_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                r_wr_cnt <= '0;
    else if (w_clr_start)                     r_wr_cnt <= '0;
    else if (w_host_wr && r_wr_cnt != 16'hFFFF) r_wr_cnt <= r_wr_cnt + 16'd1;
  end

  assign w_wr_cnt = r_wr_cnt;
`else
  assign w_wr_cnt = '0;
`endif

  always_comb begin
    status_register                          = '0;
    status_register[STAT_BUSY]               = (r_state == ST_CLEAR);
    status_register[STAT_ERROR]              = r_error;
    status_register[STAT_RVALID]             = r_read_valid;
    status_register[STAT_WCNT_LSB +: 16]     = w_wr_cnt;
  end

  assign data_o_register = {{(REG_WIDTH-16){1'b0}}, r_data_o};
  assign core_rd_data    = half_sel(w_b_rdata, r_core_sel);

  cicero_instr_mem #(
    .AW(WORD_AW),
    .DW(32)
  ) u_mem (
    .i_clk     (clk),
    .i_rst     (reset),
    .i_a_en    (w_a_en),
    .i_a_we    (w_a_we),
    .i_a_addr  (w_a_addr),
    .i_a_wdata (w_a_wdata),
    .o_a_rdata (w_a_rdata),
    .i_b_addr  (core_rd_addr[MEM_ADDR_WIDTH-1:1]),
    .o_b_rdata (w_b_rdata)
  );

endmodule

// File: doc/cicero_reg_responder.md
# cicero_reg_responder

Register-command responder that sits behind the AXI-Lite register file and executes host commands against the regex instruction memory. Each cycle it decodes the command, address and data registers, performs paired 16-bit instruction writes, single-instruction read-back, or a whole-memory clear, and reports progress in the status register. A second read-only port serves instruction fetches from the regex engine core.

## Interface
- REG_WIDTH, 32, width of every host register
- MEM_ADDR_WIDTH, 9, instruction address width (512 16-bit instructions, 256 32-bit words)
- clk  in  1  single clock; all logic is rising-edge
- reset  in  1  asynchronous, active-high
- data_in_register  in  REG_WIDTH  write data: [15:0] instruction at address, [31:16] at address+1
- address_register  in  REG_WIDTH  instruction address; only [MEM_ADDR_WIDTH-1:0] is used, higher bits must be 0
- cmd_register  in  REG_WIDTH  level command: CMD_NOP, CMD_WRITE, CMD_READ, CMD_CLEAR
- status_register  out  REG_WIDTH  bit0 busy, bit1 error (sticky), bit2 read_valid, [31:16] write count (macro)
- data_o_register  out  REG_WIDTH  {16'b0, instruction}
- core_rd_addr  in  MEM_ADDR_WIDTH  engine fetch address
- core_rd_data  out  16  engine fetch data

## Operation
- FSM states: IDLE, CLEAR, HOLD. Reset -> IDLE.
- IDLE, cmd=CMD_WRITE: every edge, if address is even and in range, write word address>>1 with data_in_register[31:0]. Writes repeat each cycle while the command is held; the last value wins. An odd or out-of-range address writes nothing and sets error.
- IDLE, cmd=CMD_READ: every edge, the address is captured into stage 1 (valid1=1). The next edge loads data_o_register with the selected half (address[0]=0 -> [15:0], address[0]=1 -> [31:16]) and sets read_valid. An out-of-range address sets error and returns 0.
- IDLE, cmd=CMD_CLEAR: go to CLEAR. busy=1, clear counter=0, error cleared.
- CLEAR: write 0 to word[counter] and increment, one word per cycle. After word 255 go to HOLD. Host commands are ignored while busy.
- HOLD: busy=0. Return to IDLE once cmd != CMD_CLEAR, so a held CLEAR never retriggers.
- CMD_NOP or any unknown encoding: no memory access. read_valid drops one edge after the last read. data_o_register holds its value.
- Core port: core_rd_data = word[core_rd_addr>>1] half-selected, with one-cycle latency and always active. If the core reads the same word the host is writing in the same cycle, the core gets the old data (read-first).

## Timing
- Reset values: status_register=0, data_o_register=0, core_rd_data=0, state IDLE. Memory contents are not reset.
- Write latency: data is visible to a read issued on the following edge.
- Read latency: address present at edge t appears on data_o_register after edge t+1. Back-to-back reads are pipelined at one result per cycle.
- Clear takes 256 cycles from the first CLEAR edge to HOLD.
- Reset asserted mid-CLEAR aborts to IDLE and leaves memory partially cleared.
- The error bit clears only on reset or CMD_CLEAR.

## Configuration
- CICERO_WRITE_COUNT_EN defined: status_register[31:16] counts accepted word writes. It saturates at 0xFFFF and is cleared by reset and CMD_CLEAR.
- CICERO_WRITE_COUNT_EN undefined: status_register[31:16] is constant 0 and the counter logic is absent.

## Structure
- AXI_package holds:
  - REG_WIDTH and the CMD_NOP/CMD_WRITE/CMD_READ/CMD_CLEAR encodings (CMD_CLEAR is a new, distinct value);
  - the responder state enum;
  - status bit-position constants.
- Sub-module cicero_instr_mem: true dual-port, 32-bit words, 2^(MEM_ADDR_WIDTH-1) deep, registered read on both ports. Port A is host read/write; port B is core read-only.

## Test plan
- Reset, then NOP -> status_register=0 and data_o_register=0.
- WRITE address 0 with data 0x0203_0104, then READ addresses 0 and 1 -> data_o_register=0x0000_0104, then 0x0000_0203, one edge after each address.
- Hold WRITE and step the address 0,2,4 with data changing every 2 cycles (streaming load) -> streaming READ of addresses 0..5 returns every instruction in order, at one per cycle once the pipeline is full.
- WRITE to address 3 -> error=1 and word 1 unchanged. With CICERO_WRITE_COUNT_EN, the count excludes this write.
- CLEAR held for 300 cycles -> busy high for exactly 256 cycles with no retrigger. A later READ of any address returns 0 and error=0. Reset at cycle 100 of a clear -> IDLE, busy=0.
- Core reads address 2 while the host writes word 1 in the same cycle -> core_rd_data shows the old value, and the new value on the next fetch.
